uart_rx_param: RTL

Parametrised asynchronous serial receiver, the next generation of the team's fixed 8N1 receiver. It has a configurable bit period and data width. It adds false-start rejection, stop-bit framing check, overrun detection and an optional parity check. It sits behind the RX pin and presents a holding register with a ready/clear handshake to the command/host logic.

---
 rtl/uart_rx_param.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parametrised async serial receiver with false-start rejection and framing/overrun flags.
// Defining UART_RX_PARITY_EN adds a parity bit after the data bits and the par_err port.
module uart_rx_param #(
  parameter int CLK_DIV    = 2604,
  parameter int DATA_BITS  = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 rx_rdy_clr,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_rdy,
  output logic                 frm_err,
  output logic                 ovr_err,
`ifdef UART_RX_PARITY_EN
  output logic                 par_err,
`endif
  output logic                 busy
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] TICK_HALF = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] TICK_FULL = CW'(CLK_DIV - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } state_t;

`ifdef UART_RX_PARITY_EN
  localparam state_t AFTER_DATA = PAR;

  function automatic logic parity_f(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
`else
  localparam state_t AFTER_DATA = STOP;

  logic unused_cfg_s;
  assign unused_cfg_s = PARITY_ODD;
`endif

  state_t                 state_r, state_nxt_s;
  logic                   rx_meta_r, rx_s;
  logic [CW-1:0]          cnt_r;
  logic [IW-1:0]          bit_idx_r;
  logic [DATA_BITS-1:0]   shift_r;
  logic                   arm_r;
  logic                   tick_s;
  logic                   stop_tick_s;

  // Two-flop synchroniser on the asynchronous line; idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_r <= 1'b1;
      rx_s      <= 1'b1;
    end else begin
      rx_meta_r <= RX;
      rx_s      <= rx_meta_r;
    end
  end

  // Next-state decode and sample-tick generation.
  always_comb begin
    state_nxt_s = state_r;
    tick_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (arm_r && !rx_s) state_nxt_s = START;
        else                state_nxt_s = IDLE;
      end
      START: begin
        if (cnt_r == TICK_HALF) begin
          tick_s      = 1'b1;
          state_nxt_s = rx_s ? IDLE : DATA;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (cnt_r == TICK_FULL) begin
          tick_s = 1'b1;
          if (bit_idx_r == LAST_IDX) state_nxt_s = AFTER_DATA;
          else                       state_nxt_s = DATA;
        end else begin
          state_nxt_s = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PAR: begin
        if (cnt_r == TICK_FULL) begin
          tick_s      = 1'b1;
          state_nxt_s = STOP;
        end else begin
          state_nxt_s = PAR;
        end
      end
`endif
      STOP: begin
        if (cnt_r == TICK_FULL) begin
          tick_s      = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = STOP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  assign stop_tick_s = (state_r == STOP) && tick_s;

  // State, baud counter, bit index, shift register and re-arm flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      busy      <= 1'b0;
      cnt_r     <= '0;
      bit_idx_r <= '0;
      shift_r   <= '0;
      arm_r     <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy    <= (state_nxt_s != IDLE);
      if ((state_r == IDLE) || tick_s || (state_nxt_s != state_r)) cnt_r <= '0;
      else                                                       cnt_r <= cnt_r + CW'(1);
      if (state_r == START)                bit_idx_r <= '0;
      else if ((state_r == DATA) && tick_s) bit_idx_r <= bit_idx_r + IW'(1);
      if ((state_r == DATA) && tick_s) shift_r <= {rx_s, shift_r[DATA_BITS-1:1]};
      // A break must return high before the next start bit is accepted.
      arm_r <= (state_r == IDLE) && (state_nxt_s == IDLE) && (arm_r || rx_s);
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_bit_r;

  // Captured parity bit and sticky parity flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit_r <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      if ((state_r == PAR) && tick_s) par_bit_r <= rx_s;
      if (stop_tick_s)
        par_err <= (par_err & ~rx_rdy_clr) | (par_bit_r ^ parity_f(shift_r) ^ PARITY_ODD);
      else if (rx_rdy_clr)
        par_err <= 1'b0;
    end
  end
`endif

  // Holding register and status flags; completion wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_data <= '0;
      rx_rdy  <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else if (stop_tick_s) begin
      rx_data <= shift_r;
      rx_rdy  <= 1'b1;
      frm_err <= (frm_err & ~rx_rdy_clr) | ~rx_s;
      ovr_err <= (ovr_err | rx_rdy) & ~rx_rdy_clr;
    end else if (rx_rdy_clr) begin
      rx_rdy  <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end
  end

endmodule
